// File: rtl/l2_noc_pkg.sv
// +--------------------------------------------------------------------------+
// | l2_noc_pkg: NoC2 header/address field layout, message codes, helpers.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package l2_noc_pkg;

    localparam int HDR_CHIPID_HI = 63;
    localparam int HDR_CHIPID_LO = 50;
    localparam int HDR_X_HI      = 49;
    localparam int HDR_X_LO      = 42;
    localparam int HDR_Y_HI      = 41;
    localparam int HDR_Y_LO      = 34;
    localparam int HDR_FBITS_HI  = 33;
    localparam int HDR_FBITS_LO  = 30;
    localparam int HDR_LEN_HI    = 29;
    localparam int HDR_LEN_LO    = 22;
    localparam int HDR_TYPE_HI   = 21;
    localparam int HDR_TYPE_LO   = 14;
    localparam int HDR_MSHRID_HI = 13;
    localparam int HDR_MSHRID_LO = 6;
    localparam int HDR_OPT_HI    = 5;
    localparam int HDR_OPT_LO    = 0;

    localparam int ADDR_TAG_HI   = 39;
    localparam int ADDR_TAG_LO   = 14;

    localparam logic [7:0] MSG_TYPE_DATA_ACK   = 8'd36;
    localparam logic [7:0] MSG_TYPE_NODATA_ACK = 8'd37;
    localparam logic [7:0] MSG_TYPE_LOAD_FWD   = 8'd16;
    localparam logic [7:0] MSG_TYPE_STORE_FWD  = 8'd17;
    localparam logic [7:0] MSG_TYPE_INV_FWD    = 8'd18;

    typedef enum logic [1:0] {
        ST_HDR  = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_HOLD = 2'd3
    } noc2_dec_state_t;

    function automatic logic [7:0] hdr_type(input logic [63:0] h);
        return h[HDR_TYPE_HI:HDR_TYPE_LO];
    endfunction

    function automatic logic [7:0] hdr_mshrid(input logic [63:0] h);
        return h[HDR_MSHRID_HI:HDR_MSHRID_LO];
    endfunction

    function automatic logic [7:0] hdr_len(input logic [63:0] h);
        return h[HDR_LEN_HI:HDR_LEN_LO];
    endfunction

    // Destination is the low three bits of y then x, matching the L2 tile grid.
    function automatic logic [5:0] hdr_dest(input logic [63:0] h);
        return {h[HDR_Y_LO+2:HDR_Y_LO], h[HDR_X_LO+2:HDR_X_LO]};
    endfunction

    function automatic logic [25:0] addr_tag(input logic [63:0] a);
        return a[ADDR_TAG_HI:ADDR_TAG_LO];
    endfunction

endpackage

`default_nettype wire

// File: rtl/l2_noc2_msg_decoder.sv
// +--------------------------------------------------------------------------+
// | l2_noc2_msg_decoder: reassembles NoC2 flits into one message record.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module l2_noc2_msg_decoder
    import l2_noc_pkg::*;
#(
    parameter int MAX_PAYLOAD = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        noc_valid_in,
    input  logic [63:0] noc_data_in,
    output logic        noc_ready_out,
    output logic        msg2_valid,
    input  logic        msg2_ready,
    output logic [7:0]  msg2_type,
    output logic [7:0]  msg2_mshrid,
    output logic [5:0]  msg2_dest,
    output logic [7:0]  msg2_len,
    output logic [25:0] msg2_tag,
    output logic [63:0] msg2_data,
    output logic        err_len
);

    localparam logic [7:0] c_max_len = 8'(MAX_PAYLOAD);

    noc2_dec_state_t state_q;
    logic        valid_q;
    logic [7:0]  type_q;
    logic [7:0]  mshrid_q;
    logic [5:0]  dest_q;
    logic [7:0]  len_q;
    logic [25:0] tag_q;
    logic [63:0] data_q;
    logic        err_q;
    logic [7:0]  rem_q;

    logic        w_accept;
    logic [7:0]  w_len;
    logic [7:0]  w_rem_dec;

    assign noc_ready_out = (state_q != ST_HOLD) || msg2_ready;
    assign w_accept      = noc_valid_in && noc_ready_out;
    assign w_len         = hdr_len(noc_data_in);
    assign w_rem_dec     = (rem_q == 8'd0) ? 8'd0 : rem_q - 8'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_HDR;
            valid_q  <= 1'b0;
            type_q   <= '0;
            mshrid_q <= '0;
            dest_q   <= '0;
            len_q    <= '0;
            tag_q    <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
            rem_q    <= '0;
        end else begin
            case (state_q)
                // HOLD shares the header path so a retiring message and the
                // next header can be exchanged in the same cycle.
                ST_HDR, ST_HOLD: begin
                    if (w_accept) begin
                        type_q   <= hdr_type(noc_data_in);
                        mshrid_q <= hdr_mshrid(noc_data_in);
                        dest_q   <= hdr_dest(noc_data_in);
                        len_q    <= w_len;
                        tag_q    <= '0;
                        data_q   <= '0;
                        rem_q    <= w_len;
                        if (w_len > c_max_len) begin
                            err_q <= 1'b1;
                        end
                        if (w_len == 8'd0) begin
                            state_q <= ST_HOLD;
                            valid_q <= 1'b1;
                        end else begin
                            state_q <= ST_ADDR;
                            valid_q <= 1'b0;
                        end
                    end else if (state_q == ST_HOLD && msg2_ready) begin
                        state_q <= ST_HDR;
                        valid_q <= 1'b0;
                    end
                end
                ST_ADDR: begin
                    if (w_accept) begin
                        tag_q <= addr_tag(noc_data_in);
                        rem_q <= w_rem_dec;
                        if (w_rem_dec == 8'd0) begin
                            state_q <= ST_HOLD;
                            valid_q <= 1'b1;
                        end else begin
                            state_q <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_accept) begin
                        // Only the flit right after the address is kept.
                        if (rem_q == len_q - 8'd1) begin
                            data_q <= noc_data_in;
                        end
                        rem_q <= w_rem_dec;
                        if (w_rem_dec == 8'd0) begin
                            state_q <= ST_HOLD;
                            valid_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_HDR;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign msg2_valid  = valid_q;
    assign msg2_type   = type_q;
    assign msg2_mshrid = mshrid_q;
    assign msg2_dest   = dest_q;
    assign msg2_len    = len_q;
    assign msg2_tag    = tag_q;
    assign msg2_data   = data_q;
    assign err_len     = err_q;

endmodule

`default_nettype wire

// File: tb/tb_l2_noc2_msg_decoder.sv
// +--------------------------------------------------------------------------+
// | tb_l2_noc2_msg_decoder: directed self-checking bench for the decoder.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_l2_noc2_msg_decoder;

    logic        clk;
    logic        rst;
    logic        noc_valid_in;
    logic [63:0] noc_data_in;
    logic        noc_ready_out;
    logic        msg2_valid;
    logic        msg2_ready;
    logic [7:0]  msg2_type;
    logic [7:0]  msg2_mshrid;
    logic [5:0]  msg2_dest;
    logic [7:0]  msg2_len;
    logic [25:0] msg2_tag;
    logic [63:0] msg2_data;
    logic        err_len;

    int n_total = 0;
    int n_bad   = 0;

    l2_noc2_msg_decoder #(.MAX_PAYLOAD(8)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .noc_valid_in (noc_valid_in),
        .noc_data_in  (noc_data_in),
        .noc_ready_out(noc_ready_out),
        .msg2_valid   (msg2_valid),
        .msg2_ready   (msg2_ready),
        .msg2_type    (msg2_type),
        .msg2_mshrid  (msg2_mshrid),
        .msg2_dest    (msg2_dest),
        .msg2_len     (msg2_len),
        .msg2_tag     (msg2_tag),
        .msg2_data    (msg2_data),
        .err_len      (err_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mk_hdr(input logic [7:0] typ, input logic [7:0] len,
                                           input logic [7:0] mshrid, input logic [7:0] y,
                                           input logic [7:0] x);
        logic [63:0] h;
        h = '0;
        h[49:42] = x;
        h[41:34] = y;
        h[29:22] = len;
        h[21:14] = typ;
        h[13:6]  = mshrid;
        return h;
    endfunction

    // Offers a flit, waits (bounded) for the handshake, returns at edge+1.
    task automatic send_flit(input logic [63:0] f, output int waited);
        waited = 0;
        noc_valid_in = 1'b1;
        noc_data_in  = f;
        @(negedge clk);
        while (!noc_ready_out && waited <= 50) begin
            waited++;
            @(negedge clk);
        end
        if (waited > 50) chk("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        noc_valid_in = 1'b0;
        noc_data_in  = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [63:0] addr_f;
    logic [63:0] d1;
    logic [63:0] d2;
    int          w;

    initial begin
        rst = 1'b1;
        noc_valid_in = 1'b0;
        noc_data_in = '0;
        msg2_ready = 1'b0;
        idle(2);
        rst = 1'b0;

        chk("rst_ready", 64'(noc_ready_out), 64'd1);
        chk("rst_valid", 64'(msg2_valid), 64'd0);
        chk("rst_type",  64'(msg2_type), 64'd0);
        chk("rst_tag",   64'(msg2_tag), 64'd0);
        chk("rst_data",  msg2_data, 64'd0);
        chk("rst_err",   64'(err_len), 64'd0);

        // Header-only packet, consumer ready.
        msg2_ready = 1'b1;
        send_flit(mk_hdr(8'h0F, 8'd0, 8'h05, 8'd3, 8'd2), w);
        chk("h0_valid",  64'(msg2_valid), 64'd1);
        chk("h0_type",   64'(msg2_type), 64'h0F);
        chk("h0_mshrid", 64'(msg2_mshrid), 64'h05);
        chk("h0_dest",   64'(msg2_dest), 64'b011010);
        chk("h0_len",    64'(msg2_len), 64'd0);
        chk("h0_tag",    64'(msg2_tag), 64'd0);
        chk("h0_data",   msg2_data, 64'd0);
        chk("h0_ready",  64'(noc_ready_out), 64'd1);
        idle(1);
        chk("h0_retire", 64'(msg2_valid), 64'd0);
        chk("h0_ready2", 64'(noc_ready_out), 64'd1);

        // Data ack, len 2, then back-pressure in HOLD.
        msg2_ready = 1'b0;
        addr_f = 64'h0000_00AB_CDEF_4000;
        d1     = 64'hDEAD_BEEF_0123_4567;
        send_flit(mk_hdr(8'd36, 8'd2, 8'h11, 8'd1, 8'd4), w);
        send_flit(addr_f, w);
        chk("da_valid_early", 64'(msg2_valid), 64'd0);
        send_flit(d1, w);
        chk("da_valid", 64'(msg2_valid), 64'd1);
        chk("da_tag",   64'(msg2_tag), 64'h2AF_37BD);
        chk("da_data",  msg2_data, 64'hDEAD_BEEF_0123_4567);
        chk("da_dest",  64'(msg2_dest), 64'b001100);
        for (int i = 0; i < 5; i++) begin
            chk("bp_ready", 64'(noc_ready_out), 64'd0);
            chk("bp_valid", 64'(msg2_valid), 64'd1);
            chk("bp_data",  msg2_data, 64'hDEAD_BEEF_0123_4567);
            chk("bp_tag",   64'(msg2_tag), 64'h2AF_37BD);
            idle(1);
        end

        // Next header offered together with msg2_ready: accepted immediately.
        msg2_ready = 1'b1;
        send_flit(mk_hdr(8'd17, 8'd3, 8'h22, 8'd5, 8'd6), w);
        chk("b2b_wait",  64'(w), 64'd0);
        chk("b2b_valid", 64'(msg2_valid), 64'd0);
        chk("b2b_type",  64'(msg2_type), 64'd17);
        chk("b2b_data",  msg2_data, 64'd0);

        // Stalled stream for the len-3 packet just started.
        msg2_ready = 1'b0;
        addr_f = 64'h0000_0012_3456_C000;
        d1     = 64'h1111_2222_3333_4444;
        d2     = 64'h5555_6666_7777_8888;
        idle(2);
        chk("st_ready_gap", 64'(noc_ready_out), 64'd1);
        send_flit(addr_f, w);
        idle(2);
        send_flit(d1, w);
        idle(2);
        chk("st_valid_early", 64'(msg2_valid), 64'd0);
        send_flit(d2, w);
        chk("st_valid", 64'(msg2_valid), 64'd1);
        chk("st_data",  msg2_data, 64'h1111_2222_3333_4444);
        chk("st_tag",   64'(msg2_tag), 64'h048_D15B);
        chk("st_len",   64'(msg2_len), 64'd3);
        chk("st_dest",  64'(msg2_dest), 64'b101110);
        msg2_ready = 1'b1;
        idle(1);
        chk("st_retire", 64'(msg2_valid), 64'd0);

        // Oversize packet: len 10 > 8.
        msg2_ready = 1'b0;
        send_flit(mk_hdr(8'd16, 8'd10, 8'h33, 8'd0, 8'd1), w);
        chk("ov_err", 64'(err_len), 64'd1);
        send_flit(64'h0000_0000_0000_C000, w);
        for (int i = 0; i < 9; i++) begin
            if (i == 8) chk("ov_valid_early", 64'(msg2_valid), 64'd0);
            send_flit(64'hA000_0000_0000_0000 + 64'(i), w);
        end
        chk("ov_valid", 64'(msg2_valid), 64'd1);
        chk("ov_len",   64'(msg2_len), 64'd10);
        chk("ov_data",  msg2_data, 64'hA000_0000_0000_0000);
        chk("ov_tag",   64'(msg2_tag), 64'd3);
        msg2_ready = 1'b1;
        idle(1);
        chk("ov_retire", 64'(msg2_valid), 64'd0);

        // Legal packet after oversize, len 1.
        msg2_ready = 1'b0;
        send_flit(mk_hdr(8'd37, 8'd1, 8'h44, 8'd2, 8'd2), w);
        send_flit(64'h0000_0000_0001_0000, w);
        chk("l1_valid", 64'(msg2_valid), 64'd1);
        chk("l1_tag",   64'(msg2_tag), 64'd4);
        chk("l1_data",  msg2_data, 64'd0);
        chk("l1_type",  64'(msg2_type), 64'd37);
        chk("l1_err",   64'(err_len), 64'd1);
        msg2_ready = 1'b1;
        idle(1);

        // Reset after the address flit.
        msg2_ready = 1'b0;
        send_flit(mk_hdr(8'd36, 8'd2, 8'h55, 8'd1, 8'd1), w);
        send_flit(64'h0000_0000_0000_4000, w);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("mr_valid", 64'(msg2_valid), 64'd0);
        chk("mr_type",  64'(msg2_type), 64'd0);
        chk("mr_tag",   64'(msg2_tag), 64'd0);
        chk("mr_err",   64'(err_len), 64'd0);
        chk("mr_ready", 64'(noc_ready_out), 64'd1);
        send_flit(mk_hdr(8'd18, 8'd0, 8'h66, 8'd7, 8'd7), w);
        chk("fr_valid",  64'(msg2_valid), 64'd1);
        chk("fr_type",   64'(msg2_type), 64'd18);
        chk("fr_mshrid", 64'(msg2_mshrid), 64'h66);
        chk("fr_dest",   64'(msg2_dest), 64'b111111);
        chk("fr_tag",    64'(msg2_tag), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
